// File: rtl/page_illm_d1_row_gather_if.sv
// Lane-side and row-side handshake bundle for the row gather stage.
// The slave modport is the gather stage; the master modport is its environment.
interface page_illm_d1_row_gather_if #(
    parameter int W     = 16,
    parameter int CNT_W = 16
);
    logic [W-1:0]     a_d [8];
    logic [7:0]       a_e;
    logic [7:0]       a_v;
    logic [7:0]       a_b;
    logic [8*W-1:0]   row_d;
    logic             row_e;
    logic             row_v;
    logic             row_b;
    logic [CNT_W-1:0] rows_cnt;
    logic             eos_err;

    modport master (
        output a_d, a_e, a_v, row_b,
        input  a_b, row_d, row_e, row_v, rows_cnt, eos_err
    );

    modport slave (
        input  a_d, a_e, a_v, row_b,
        output a_b, row_d, row_e, row_v, rows_cnt, eos_err
    );
endinterface

// File: rtl/page_illm_d1_row_gather.sv
// Collects one token per lane from eight independent queues and issues one aligned
// 8-word row (or a single eos row) per firing to the 1-D IDCT datapath.
module page_illm_d1_row_gather #(
    parameter int W     = 16,
    parameter int CNT_W = 16
) (
    input  logic clock,
    input  logic reset,
    page_illm_d1_row_gather_if.slave bus
);
    typedef enum logic {COLLECT = 1'b0, DONE = 1'b1} state_t;

    state_t           state_reg, state_next;
    logic [W-1:0]     hd_reg [8];
    logic [7:0]       he_reg;
    logic [7:0]       full_reg;
    logic [7:0]       lane_b;
    logic [8*W-1:0]   hold_row;
    logic [8*W-1:0]   row_d_reg;
    logic             row_e_reg;
    logic             row_v_reg;
    logic [CNT_W-1:0] rows_cnt_reg;
    logic             eos_err_reg;

    logic out_free, fire, fire_data, fire_eos, fire_mixed, handoff;

    // Output register can take a new row if empty or being drained on this edge.
    assign handoff  = row_v_reg & ~bus.row_b;
    assign out_free = ~row_v_reg | ~bus.row_b;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign lane_b[gi]               = reset | full_reg[gi] | (state_reg == DONE);
            assign hold_row[gi*W +: W]      = hd_reg[gi];

            always_ff @(posedge clock) begin
                if (reset) begin
                    full_reg[gi] <= 1'b0;
                    he_reg[gi]   <= 1'b0;
                    hd_reg[gi]   <= '0;
                end else if (fire) begin
                    full_reg[gi] <= 1'b0;
                end else if (bus.a_v[gi] && !lane_b[gi]) begin
                    full_reg[gi] <= 1'b1;
                    he_reg[gi]   <= bus.a_e[gi];
                    hd_reg[gi]   <= bus.a_d[gi];
                end
            end
        end
    endgenerate

    assign bus.a_b = lane_b;

    always_comb begin
        state_next = state_reg;
        fire       = 1'b0;
        fire_data  = 1'b0;
        fire_eos   = 1'b0;
        fire_mixed = 1'b0;
        if (state_reg == COLLECT && (&full_reg) && out_free) begin
            fire = 1'b1;
            if (he_reg == 8'h00) begin
                fire_data = 1'b1;
            end else if (he_reg == 8'hFF) begin
                fire_eos   = 1'b1;
                state_next = DONE;
            end else begin
                fire_mixed = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= COLLECT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            row_d_reg    <= '0;
            row_e_reg    <= 1'b0;
            row_v_reg    <= 1'b0;
            rows_cnt_reg <= '0;
            eos_err_reg  <= 1'b0;
        end else begin
            if (fire_data) begin
                row_d_reg <= hold_row;
                row_e_reg <= 1'b0;
                row_v_reg <= 1'b1;
            end else if (fire_eos) begin
                row_d_reg <= '0;
                row_e_reg <= 1'b1;
                row_v_reg <= 1'b1;
            end else if (handoff) begin
                row_v_reg <= 1'b0;
            end
            // Only data rows count; the eos row is a stream marker.
            if (handoff && !row_e_reg) begin
                rows_cnt_reg <= rows_cnt_reg + 1'b1;
            end
            if (fire_mixed) begin
                eos_err_reg <= 1'b1;
            end
        end
    end

    assign bus.row_d    = row_d_reg;
    assign bus.row_e    = row_e_reg;
    assign bus.row_v    = row_v_reg;
    assign bus.rows_cnt = rows_cnt_reg;
    assign bus.eos_err  = eos_err_reg;
endmodule

// File: tb/tb_page_illm_d1_row_gather.sv
// Scoreboard bench for page_illm_d1_row_gather: expected rows are queued when lanes are
// offered and compared when the output handshake completes.
module tb_page_illm_d1_row_gather;
    localparam int W     = 16;
    localparam int CNT_W = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    page_illm_d1_row_gather_if #(.W(W), .CNT_W(CNT_W)) bus ();

    page_illm_d1_row_gather #(.W(W), .CNT_W(CNT_W)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    logic [8*W:0] exp_q [$];
    logic [8*W:0] exp_ent;

    // Output monitor: a handoff happens on the next edge when row_v=1 and row_b=0.
    always @(negedge clock) begin
        if (!reset && bus.row_v && !bus.row_b) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL row_unexpected: got e=%0b d=%h, required no row", bus.row_e, bus.row_d);
            end else begin
                exp_ent = exp_q.pop_front();
                if ({bus.row_e, bus.row_d} !== exp_ent) begin
                    n_fail++;
                    $display("FAIL row_data: got e=%0b d=%h, required e=%0b d=%h",
                             bus.row_e, bus.row_d, exp_ent[8*W], exp_ent[8*W-1:0]);
                end else begin
                    $display("row handoff e=%0b d=%h", bus.row_e, bus.row_d);
                end
            end
        end
    end

    // One clock; lanes whose token was taken on this edge drop their valid.
    task automatic tick();
        logic [7:0] x;
        @(negedge clock);
        x = bus.a_v & ~bus.a_b;
        @(posedge clock);
        #1;
        bus.a_v = bus.a_v & ~x;
    endtask

    task automatic offer_lanes(input logic [8*W-1:0] row, input logic [7:0] emask,
                               input logic [7:0] lanes);
        for (int k = 0; k < 8; k++) begin
            if (lanes[k]) begin
                bus.a_d[k] = row[k*W +: W];
                bus.a_e[k] = emask[k];
            end
        end
        bus.a_v = bus.a_v | lanes;
    endtask

    function automatic logic [8*W-1:0] rand_row();
        logic [8*W-1:0] r;
        for (int k = 0; k < 8; k++) r[k*W +: W] = W'($urandom);
        return r;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        bus.a_v = '0;
        bus.a_e = '0;
        bus.row_b = 1'b0;
        for (int k = 0; k < 8; k++) bus.a_d[k] = '0;
        tick();
        tick();
        n_cmp++; if (bus.a_b !== 8'hFF) begin n_fail++; $display("FAIL reset_b: got %h, required ff", bus.a_b); end
        n_cmp++; if ({bus.row_v, bus.row_e, bus.eos_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b, required 000", {bus.row_v, bus.row_e, bus.eos_err}); end
        n_cmp++; if (bus.rows_cnt !== '0 || bus.row_d !== '0) begin n_fail++; $display("FAIL reset_regs: got cnt=%h d=%h, required 0", bus.rows_cnt, bus.row_d); end
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.a_b !== 8'h00) begin n_fail++; $display("FAIL release_b: got %h, required 00", bus.a_b); end
    endtask

    task automatic test_simultaneous();
        logic [8*W-1:0] row;
        for (int k = 0; k < 8; k++) row[k*W +: W] = 16'h0010 + 16'(k);
        exp_q.push_back({1'b0, row});
        offer_lanes(row, 8'h00, 8'hFF);
        tick();
        n_cmp++; if (bus.a_b !== 8'hFF || bus.row_v !== 1'b0) begin n_fail++; $display("FAIL sim_accept: got b=%h v=%b, required b=ff v=0", bus.a_b, bus.row_v); end
        tick();
        n_cmp++; if (bus.row_v !== 1'b1 || bus.row_d !== row || bus.row_e !== 1'b0) begin n_fail++; $display("FAIL sim_fire: got v=%b e=%b d=%h, required v=1 e=0 d=%h", bus.row_v, bus.row_e, bus.row_d, row); end
        tick();
        n_cmp++; if (bus.rows_cnt !== 16'd1 || bus.row_v !== 1'b0) begin n_fail++; $display("FAIL sim_count: got cnt=%0d v=%b, required cnt=1 v=0", bus.rows_cnt, bus.row_v); end
    endtask

    task automatic test_staggered();
        logic [8*W-1:0] row;
        row = rand_row();
        exp_q.push_back({1'b0, row});
        for (int k = 0; k < 8; k++) begin
            offer_lanes(row, 8'h00, 8'(1 << k));
            tick();
            n_cmp++; if (bus.a_b[k] !== 1'b1 || bus.row_v !== 1'b0) begin n_fail++; $display("FAIL stag_hold%0d: got b=%b v=%b, required b=1 v=0", k, bus.a_b[k], bus.row_v); end
            if (k < 7) begin
                tick();
                tick();
            end
        end
        tick();
        n_cmp++; if (bus.row_v !== 1'b1 || bus.row_d !== row) begin n_fail++; $display("FAIL stag_fire: got v=%b d=%h, required v=1 d=%h", bus.row_v, bus.row_d, row); end
        tick();
        n_cmp++; if (bus.rows_cnt !== 16'd2) begin n_fail++; $display("FAIL stag_count: got %0d, required 2", bus.rows_cnt); end
    endtask

    task automatic test_backpressure();
        logic [8*W-1:0] ra, rb;
        ra = rand_row();
        rb = rand_row();
        exp_q.push_back({1'b0, ra});
        exp_q.push_back({1'b0, rb});
        bus.row_b = 1'b1;
        offer_lanes(ra, 8'h00, 8'hFF);
        tick();
        tick();
        offer_lanes(rb, 8'h00, 8'hFF);
        tick();
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (bus.row_v !== 1'b1 || bus.row_d !== ra || bus.a_b !== 8'hFF) begin n_fail++; $display("FAIL bp_hold%0d: got v=%b b=%h d=%h, required v=1 b=ff d=%h", i, bus.row_v, bus.a_b, bus.row_d, ra); end
            tick();
        end
        n_cmp++; if (bus.rows_cnt !== 16'd2) begin n_fail++; $display("FAIL bp_stall_count: got %0d, required 2", bus.rows_cnt); end
        bus.row_b = 1'b0;
        tick();
        n_cmp++; if (bus.row_v !== 1'b1 || bus.row_d !== rb) begin n_fail++; $display("FAIL bp_b2b: got v=%b d=%h, required v=1 d=%h", bus.row_v, bus.row_d, rb); end
        tick();
        n_cmp++; if (bus.rows_cnt !== 16'd4 || bus.row_v !== 1'b0) begin n_fail++; $display("FAIL bp_count: got cnt=%0d v=%b, required cnt=4 v=0", bus.rows_cnt, bus.row_v); end
    endtask

    task automatic test_mixed_eos();
        logic [8*W-1:0] row;
        offer_lanes(rand_row(), 8'h08, 8'hFF);
        tick();
        tick();
        n_cmp++; if (bus.eos_err !== 1'b1 || bus.row_v !== 1'b0 || bus.a_b !== 8'h00) begin n_fail++; $display("FAIL mixed_drop: got err=%b v=%b b=%h, required err=1 v=0 b=00", bus.eos_err, bus.row_v, bus.a_b); end
        row = rand_row();
        exp_q.push_back({1'b0, row});
        offer_lanes(row, 8'h00, 8'hFF);
        tick();
        tick();
        tick();
        n_cmp++; if (bus.rows_cnt !== 16'd5 || bus.eos_err !== 1'b1) begin n_fail++; $display("FAIL mixed_after: got cnt=%0d err=%b, required cnt=5 err=1", bus.rows_cnt, bus.eos_err); end
    endtask

    task automatic test_eos();
        exp_q.push_back({1'b1, {(8*W){1'b0}}});
        offer_lanes(rand_row(), 8'hFF, 8'hFF);
        tick();
        tick();
        n_cmp++; if (bus.row_v !== 1'b1 || bus.row_e !== 1'b1 || bus.row_d !== '0) begin n_fail++; $display("FAIL eos_row: got v=%b e=%b d=%h, required v=1 e=1 d=0", bus.row_v, bus.row_e, bus.row_d); end
        tick();
        n_cmp++; if (bus.rows_cnt !== 16'd5 || bus.row_v !== 1'b0) begin n_fail++; $display("FAIL eos_count: got cnt=%0d v=%b, required cnt=5 v=0", bus.rows_cnt, bus.row_v); end
        offer_lanes(rand_row(), 8'h00, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (bus.a_b !== 8'hFF || bus.row_v !== 1'b0) begin n_fail++; $display("FAIL done_block%0d: got b=%h v=%b, required b=ff v=0", i, bus.a_b, bus.row_v); end
        end
        bus.a_v = '0;
    endtask

    task automatic test_reset_mid();
        logic [8*W-1:0] row;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        offer_lanes(rand_row(), 8'h01, 8'hFF);
        tick();
        tick();
        bus.row_b = 1'b1;
        offer_lanes(rand_row(), 8'h00, 8'hFF);
        tick();
        tick();
        offer_lanes(rand_row(), 8'h00, 8'h0F);
        tick();
        n_cmp++; if (bus.row_v !== 1'b1 || bus.a_b !== 8'h0F || bus.eos_err !== 1'b1) begin n_fail++; $display("FAIL mid_setup: got v=%b b=%h err=%b, required v=1 b=0f err=1", bus.row_v, bus.a_b, bus.eos_err); end
        reset = 1'b1;
        bus.a_v = '0;
        tick();
        n_cmp++; if (bus.row_v !== 1'b0 || bus.rows_cnt !== '0 || bus.eos_err !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got v=%b cnt=%0d err=%b, required v=0 cnt=0 err=0", bus.row_v, bus.rows_cnt, bus.eos_err); end
        reset = 1'b0;
        bus.row_b = 1'b0;
        row = rand_row();
        offer_lanes(row, 8'h00, 8'hF0);
        tick();
        tick();
        tick();
        n_cmp++; if (bus.row_v !== 1'b0 || bus.a_b !== 8'hF0) begin n_fail++; $display("FAIL mid_empty: got v=%b b=%h, required v=0 b=f0", bus.row_v, bus.a_b); end
        exp_q.push_back({1'b0, row});
        offer_lanes(row, 8'h00, 8'h0F);
        tick();
        tick();
        n_cmp++; if (bus.row_v !== 1'b1 || bus.row_d !== row) begin n_fail++; $display("FAIL mid_fire: got v=%b d=%h, required v=1 d=%h", bus.row_v, bus.row_d, row); end
        tick();
        n_cmp++; if (bus.rows_cnt !== 16'd1) begin n_fail++; $display("FAIL mid_count: got %0d, required 1", bus.rows_cnt); end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_staggered();
        test_backpressure();
        test_mixed_eos();
        test_eos();
        test_reset_mid();
        tick();
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rows_missing: got %0d pending, required 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
